// File: rtl/hood_pkg.sv
// Shared range-hood constants: mode codes used by the mode FSM, display and
// timers, plus the hurricane timer state encoding.
package hood_pkg;

  localparam logic [2:0] MODE_STANDBY   = 3'b000;
  localparam logic [2:0] MODE_1         = 3'b001;
  localparam logic [2:0] MODE_2         = 3'b010;
  localparam logic [2:0] MODE_HURRICANE = 3'b011;
  localparam logic [2:0] MODE_CLEAN     = 3'b100;
  localparam logic [2:0] MODE_SHOW_GEST = 3'b110;
  localparam logic [2:0] MODE_SHOW_CUM  = 3'b111;

  typedef enum logic [1:0] {
    TMR_IDLE    = 2'b00,
    TMR_RUN     = 2'b01,
    TMR_DONE    = 2'b10,
    TMR_LOCKOUT = 2'b11
  } timer_state_e;

  function automatic logic is_hurricane(input logic [2:0] mode);
    return (mode == MODE_HURRICANE);
  endfunction

endpackage

// File: rtl/sec_tick.sv
// Seconds prescaler: counts 0..CLK_HZ-1 while enabled and flags the terminal
// count as a one-cycle tick. A synchronous clear restarts the second.
module sec_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] TERM = W'(CLK_HZ - 1);
  localparam logic [W-1:0] ZERO = W'(0);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = en & (cnt_q == TERM);

  // Next prescaler value: clear wins, terminal count wraps to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = ZERO;
    end else if (tick) begin
      cnt_d = ZERO;
    end else if (en) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hurricane_timer.sv
// Hurricane (mode 3) supervisor: times the run, latches a menu press during it,
// and holds off re-entry through a lockout period.
module hurricane_timer
  import hood_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int RUN_SEC     = 60,
  parameter int LOCKOUT_SEC = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       machine_state,
  input  logic [2:0] mode_state,
  input  logic       menu_btn,
  output logic       hurricane_mode_enabled,
  output logic       return_state,
  output logic [7:0] sec_left,
  output logic       timer_active
);

  localparam logic [7:0] RUN_LOAD  = 8'(RUN_SEC);
  localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT_SEC);
  localparam logic       LOCK_TIMED = (LOCKOUT_SEC != 0);

  timer_state_e state_q, state_d;
  logic       enabled_q, enabled_d;
  logic       ret_q, ret_d;
  logic [7:0] sec_q, sec_d;
  logic       active_q, active_d;
  logic       menu_prev_q;

  logic hur;
  logic menu_rise;
  logic tick;
  logic tick_en;
  logic tick_clr;

  assign hur       = is_hurricane(mode_state);
  assign menu_rise = menu_btn & ~menu_prev_q;
  assign tick_en   = (state_q == TMR_RUN) | ((state_q == TMR_LOCKOUT) & LOCK_TIMED);
  // Every state change (and power-off) starts a fresh second.
  assign tick_clr  = ~machine_state | (state_d != state_q);

  sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  // Next-state and next-output logic; power-off overrides everything.
  always_comb begin
    state_d   = state_q;
    enabled_d = enabled_q;
    ret_d     = ret_q;
    sec_d     = sec_q;
    active_d  = active_q;
    if (!machine_state) begin
      state_d   = TMR_IDLE;
      enabled_d = 1'b1;
      ret_d     = 1'b0;
      sec_d     = 8'd0;
      active_d  = 1'b0;
    end else begin
      case (state_q)
        TMR_IDLE: begin
          enabled_d = 1'b1;
          if (hur) begin
            state_d  = TMR_RUN;
            sec_d    = RUN_LOAD;
            ret_d    = 1'b0;
            active_d = 1'b1;
          end else begin
            state_d = TMR_IDLE;
          end
        end
        TMR_RUN: begin
          if (menu_rise) begin
            ret_d = 1'b1;
          end else begin
            ret_d = ret_q;
          end
          // The final tick takes precedence so a coincident menu edge survives.
          if (tick && (sec_q == 8'd1)) begin
            state_d   = TMR_DONE;
            sec_d     = 8'd0;
            enabled_d = 1'b0;
            active_d  = 1'b0;
          end else if (!hur) begin
            state_d   = TMR_LOCKOUT;
            sec_d     = LOCK_LOAD;
            enabled_d = 1'b0;
            ret_d     = 1'b0;
            active_d  = 1'b0;
          end else if (tick) begin
            sec_d = sec_q - 8'd1;
          end else begin
            sec_d = sec_q;
          end
        end
        TMR_DONE: begin
          enabled_d = 1'b0;
          if (!hur) begin
            state_d = TMR_LOCKOUT;
            sec_d   = LOCK_LOAD;
            ret_d   = 1'b0;
          end else begin
            state_d = TMR_DONE;
          end
        end
        TMR_LOCKOUT: begin
          enabled_d = 1'b0;
          ret_d     = 1'b0;
          active_d  = 1'b0;
          if (tick && (sec_q == 8'd1)) begin
            state_d   = TMR_IDLE;
            sec_d     = 8'd0;
            enabled_d = 1'b1;
          end else if (tick) begin
            sec_d = sec_q - 8'd1;
          end else begin
            sec_d = sec_q;
          end
        end
        default: begin
          state_d   = TMR_IDLE;
          enabled_d = 1'b1;
          ret_d     = 1'b0;
          sec_d     = 8'd0;
          active_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; menu_prev tracks the button in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= TMR_IDLE;
      enabled_q   <= 1'b1;
      ret_q       <= 1'b0;
      sec_q       <= 8'd0;
      active_q    <= 1'b0;
      menu_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      enabled_q   <= enabled_d;
      ret_q       <= ret_d;
      sec_q       <= sec_d;
      active_q    <= active_d;
      menu_prev_q <= menu_btn;
    end
  end

  assign hurricane_mode_enabled = enabled_q;
  assign return_state           = ret_q;
  assign sec_left               = sec_q;
  assign timer_active           = active_q;

endmodule

// File: tb/tb_hurricane_timer.sv
// Self-checking bench for hurricane_timer: directed vector table, hand-written
// corner sequences, and random stimulus against a cycle-count reference model.
module tb_hurricane_timer;

  localparam int CLK_HZ  = 10;
  localparam int RUN_SEC = 3;
  localparam int LOCK    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ms = 1'b1;
  logic [2:0] mode = 3'b000;
  logic       menu = 1'b0;

  logic       en1, ret1, act1;
  logic [7:0] sec1;
  logic       en2, ret2, act2;
  logic [7:0] sec2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hurricane_timer #(.CLK_HZ(CLK_HZ), .RUN_SEC(RUN_SEC), .LOCKOUT_SEC(LOCK)) u_dut (
    .clk(clk), .rst(rst), .machine_state(ms), .mode_state(mode), .menu_btn(menu),
    .hurricane_mode_enabled(en1), .return_state(ret1), .sec_left(sec1), .timer_active(act1)
  );

  hurricane_timer #(.CLK_HZ(CLK_HZ), .RUN_SEC(RUN_SEC), .LOCKOUT_SEC(0)) u_dut_perm (
    .clk(clk), .rst(rst), .machine_state(ms), .mode_state(mode), .menu_btn(menu),
    .hurricane_mode_enabled(en2), .return_state(ret2), .sec_left(sec2), .timer_active(act2)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic power_cycle();
    ms = 1'b0; mode = 3'b000; menu = 1'b0;
    step();
    ms = 1'b1;
  endtask

  // Reference model: tracks phase and cycles elapsed since the phase began.
  localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2, P_LOCK = 3;
  typedef struct {
    int phase; int elapsed; int sec; bit en; bit ret; bit act; bit prev;
  } mdl_t;

  function automatic mdl_t mreset();
    mdl_t m;
    m.phase = P_IDLE; m.elapsed = 0; m.sec = 0;
    m.en = 1'b1; m.ret = 1'b0; m.act = 1'b0; m.prev = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t s, bit pwr, logic [2:0] md, bit mb, int lock);
    mdl_t n = s;
    bit hur = (md == 3'b011);
    bit rise = mb & ~s.prev;
    if (!pwr) begin
      n = mreset();
    end else begin
      case (s.phase)
        P_IDLE: if (hur) begin
          n.phase = P_RUN; n.elapsed = 0; n.sec = RUN_SEC; n.ret = 1'b0; n.act = 1'b1;
        end
        P_RUN: begin
          n.elapsed = s.elapsed + 1;
          if (rise) n.ret = 1'b1;
          if (n.elapsed == RUN_SEC * CLK_HZ) begin
            n.phase = P_DONE; n.sec = 0; n.en = 1'b0; n.act = 1'b0;
          end else if (!hur) begin
            n.phase = P_LOCK; n.elapsed = 0; n.sec = lock; n.en = 1'b0; n.ret = 1'b0; n.act = 1'b0;
          end else begin
            n.sec = RUN_SEC - n.elapsed / CLK_HZ;
          end
        end
        P_DONE: if (!hur) begin
          n.phase = P_LOCK; n.elapsed = 0; n.sec = lock; n.ret = 1'b0;
        end
        default: if (lock > 0) begin
          n.elapsed = s.elapsed + 1;
          if (n.elapsed == lock * CLK_HZ) begin
            n.phase = P_IDLE; n.sec = 0; n.en = 1'b1;
          end else begin
            n.sec = lock - n.elapsed / CLK_HZ;
          end
        end
      endcase
    end
    n.prev = mb;
    return n;
  endfunction

  typedef struct {
    bit ms; logic [2:0] mode; bit menu; int n;
    bit en; bit ret; int sec; bit act;
  } vec_t;

  vec_t tbl[14];

  initial begin
    mdl_t m1, m2;
    int hold;

    tbl[0]  = '{1'b1, 3'b000, 1'b0, 2,  1'b1, 1'b0, 0, 1'b0};
    tbl[1]  = '{1'b1, 3'b011, 1'b0, 1,  1'b1, 1'b0, 3, 1'b1};
    tbl[2]  = '{1'b1, 3'b011, 1'b0, 9,  1'b1, 1'b0, 3, 1'b1};
    tbl[3]  = '{1'b1, 3'b011, 1'b0, 1,  1'b1, 1'b0, 2, 1'b1};
    tbl[4]  = '{1'b1, 3'b011, 1'b0, 10, 1'b1, 1'b0, 1, 1'b1};
    tbl[5]  = '{1'b1, 3'b011, 1'b0, 9,  1'b1, 1'b0, 1, 1'b1};
    tbl[6]  = '{1'b1, 3'b011, 1'b0, 1,  1'b0, 1'b0, 0, 1'b0};
    tbl[7]  = '{1'b1, 3'b011, 1'b0, 5,  1'b0, 1'b0, 0, 1'b0};
    tbl[8]  = '{1'b1, 3'b010, 1'b0, 1,  1'b0, 1'b0, 2, 1'b0};
    tbl[9]  = '{1'b1, 3'b011, 1'b0, 10, 1'b0, 1'b0, 1, 1'b0};
    tbl[10] = '{1'b1, 3'b011, 1'b0, 9,  1'b0, 1'b0, 1, 1'b0};
    tbl[11] = '{1'b1, 3'b011, 1'b0, 1,  1'b1, 1'b0, 0, 1'b0};
    tbl[12] = '{1'b1, 3'b011, 1'b0, 1,  1'b1, 1'b0, 3, 1'b1};
    tbl[13] = '{1'b0, 3'b011, 1'b0, 1,  1'b1, 1'b0, 0, 1'b0};

    // Asynchronous reset values.
    #2 rst = 1'b0;
    step();
    check("rst_en", int'(en1), 1);
    check("rst_ret_sec_act", int'({ret1, act1, sec1}), 0);
    rst = 1'b1;

    // Directed table: plain run, DONE hold, timed lockout, re-entry, power-off.
    for (int i = 0; i < 14; i++) begin
      ms = tbl[i].ms; mode = tbl[i].mode; menu = tbl[i].menu;
      repeat (tbl[i].n) step();
      check($sformatf("tbl%0d", i), int'({en1, ret1, act1, sec1}),
            int'({tbl[i].en, tbl[i].ret, tbl[i].act, 8'(tbl[i].sec)}));
    end

    // Menu pulse at cycle 12 of the run.
    power_cycle();
    mode = 3'b011;
    step();
    repeat (12) step();
    check("menu_before", int'(ret1), 0);
    menu = 1'b1;
    step();
    check("menu_latched", int'(ret1), 1);
    menu = 1'b0;
    repeat (16) step();
    check("menu_hold_en", int'({en1, ret1}), 3);
    step();
    check("menu_final_edge", int'({en1, ret1, act1}), 2);
    step();
    check("menu_done_hold", int'({en1, ret1}), 1);
    mode = 3'b010;
    step();
    check("menu_lockout_clear", int'({ret1, sec1}), 2);

    // Menu rising edge on the final-tick cycle.
    power_cycle();
    mode = 3'b011;
    step();
    repeat (29) step();
    check("coinc_pre", int'({en1, ret1, sec1}), 'h201);
    menu = 1'b1;
    step();
    check("coinc_final", int'({en1, ret1, sec1}), 'h100);
    menu = 1'b0;

    // Power-off at cycle 15 of the run.
    power_cycle();
    mode = 3'b011;
    step();
    repeat (15) step();
    check("poff_mid_sec", int'(sec1), 2);
    ms = 1'b0;
    step();
    check("poff_reset", int'({en1, ret1, act1, sec1}), 'h400);
    ms = 1'b1;
    step();
    check("poff_idle_reenter", int'({act1, sec1}), 'h103);

    // Permanent lockout on the LOCKOUT_SEC=0 instance.
    power_cycle();
    mode = 3'b011;
    step();
    repeat (30) step();
    check("perm_done", int'({en2, sec2}), 0);
    mode = 3'b010;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (i == 500) mode = 3'b011;
      check("perm_hold", int'({en2, sec2}), 0);
    end
    ms = 1'b0;
    step();
    check("perm_release", int'(en2), 1);

    // Random stimulus against the reference model, both lockout flavours.
    m1 = mreset();
    m2 = mreset();
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c == 0) ms = 1'b0;
      else ms = ($urandom_range(0, 299) != 0);
      if (hold == 0) begin
        hold = $urandom_range(1, 80);
        mode = ($urandom_range(0, 9) < 6) ? 3'b011 : 3'($urandom_range(0, 7));
      end
      hold--;
      if ($urandom_range(0, 7) == 0) menu = ~menu;
      m1 = mstep(m1, ms, mode, menu, LOCK);
      m2 = mstep(m2, ms, mode, menu, 0);
      step();
      check("rand_lock2", int'({en1, ret1, act1, sec1}),
            int'({m1.en, m1.ret, m1.act, 8'(m1.sec)}));
      check("rand_lock0", int'({en2, ret2, act2, sec2}),
            int'({m2.en, m2.ret, m2.act, 8'(m2.sec)}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hurricane_timer.md
# hurricane_timer

Upstream timing stage for the range-hood mode FSM: it supervises hurricane (mode 3) runs and drives the FSM's `hurricane_mode_enabled` and `return_state` inputs. It runs the mode-3 countdown, records whether the user pressed menu during the run, and enforces a lockout before hurricane may be re-entered. It also exports the remaining seconds for the display stage.

## Interface
Parameters:
- CLK_HZ, 100_000_000, clock cycles per second tick
- RUN_SEC, 60, hurricane run length in seconds (1..255)
- LOCKOUT_SEC, 0, post-run lockout in seconds; 0 = locked until power-off

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- machine_state  in  1  1 = hood powered on
- mode_state  in  3  current mode from the mode FSM; 3'b011 = hurricane
- menu_btn  in  1  debounced menu button level
- hurricane_mode_enabled  out  1  1 = hurricane may be entered or continue
- return_state  out  1  1 = menu pressed during the run; FSM exits to mode 2, otherwise to standby
- sec_left  out  8  seconds remaining in RUN or LOCKOUT; 0 otherwise
- timer_active  out  1  1 while in RUN

## Operation
- States: IDLE, RUN, DONE, LOCKOUT.
- Reset values: state IDLE, hurricane_mode_enabled=1, return_state=0, sec_left=0, timer_active=0, prescaler=0, menu_prev=0.
- Power-off: if machine_state=0, the next edge forces the reset values in any state. This abort has priority over every other event.
- IDLE: enabled=1. When mode_state==3'b011, go to RUN: sec_left=RUN_SEC, return_state=0, prescaler=0, timer_active=1.
- RUN: the prescaler counts 0..CLK_HZ-1. The terminal count is a tick; on a tick sec_left decrements.
  - Tick with sec_left==1: sec_left=0, enabled=0, timer_active=0, go to DONE.
  - menu_btn rising edge (menu_btn & ~menu_prev) sets return_state=1. return_state is sticky until LOCKOUT entry.
  - mode_state leaving 3'b011 early: go straight to LOCKOUT (enabled=0, return_state=0).
- DONE: enabled=0. Menu edges are ignored. When mode_state != 3'b011, go to LOCKOUT.
- LOCKOUT: enabled=0, return_state=0.
  - LOCKOUT_SEC>0: load sec_left=LOCKOUT_SEC, prescaler=0, decrement on ticks. On the tick with sec_left==1, set sec_left=0, enabled=1, go to IDLE.
  - LOCKOUT_SEC==0: sec_left stays 0 and the block stays in LOCKOUT until power-off.
- Simultaneous final tick and menu edge: both apply; return_state=1 and enabled=0 on the same edge.
- menu_prev updates every cycle in all states, including power-off.

## Timing
- All outputs are registered.
- mode_state==3'b011 sampled at edge t gives RUN with sec_left=RUN_SEC after edge t.
- The first RUN tick is exactly CLK_HZ cycles after RUN entry. Every later tick follows CLK_HZ cycles after the previous one.
- enabled falls on the edge of the RUN_SEC-th tick, i.e. RUN_SEC*CLK_HZ cycles after RUN entry. return_state is valid on that same edge and holds through DONE, so the FSM samples a stable value.
- A menu edge takes 1 cycle to reach return_state.
- DONE to LOCKOUT happens 1 cycle after mode_state leaves 3'b011.
- Power-off takes 1 cycle to reach the reset values.

## Structure
- Shared package (`hood_pkg`): mode codes (MODE_STANDBY=3'b000, MODE_1=3'b001, MODE_2=3'b010, MODE_HURRICANE=3'b011, MODE_CLEAN=3'b100, MODE_SHOW_CUM=3'b111, MODE_SHOW_GEST=3'b110) and the timer state encoding. The mode FSM and the display use the same constants.
- Sub-module `sec_tick`: prescaler with a synchronous clear input and a one-cycle tick output, sized $clog2(CLK_HZ). It is reused by the self-clean and display timers.

## Test plan
(Bench parameters: CLK_HZ=10, RUN_SEC=3, LOCKOUT_SEC=2.)
- Plain run: power on, mode_state=3'b011 held -> sec_left 3,2,1 at 10-cycle spacing; enabled=0 and return_state=0 exactly 30 cycles after RUN entry.
- Menu during run: menu pulse at cycle 12 of RUN -> return_state=1 from cycle 13, still 1 when enabled falls; cleared on LOCKOUT entry.
- Lockout: after DONE, mode_state=3'b010 -> LOCKOUT with sec_left=2; enabled=1 20 cycles later; re-entering 3'b011 during lockout keeps enabled=0.
- Coincident events: menu rising edge on the final-tick cycle -> enabled=0 and return_state=1 on the same edge.
- Power-off mid-run: machine_state=0 at cycle 15 of RUN -> next edge enabled=1, return_state=0, sec_left=0, state IDLE.
- Permanent lockout: LOCKOUT_SEC=0 -> enabled stays 0 for 1000 cycles after the run; returns to 1 one cycle after machine_state=0.
